reg_pipeline: RTL

Parametrised register delay line that generalises the fixed two-stage `a -> b -> c` register chain to WIDTH bits and DEPTH stages. It adds per-stage valid tracking, a stall enable, a synchronous flush and an optional occupancy count. It sits between a producer and a consumer that need a fixed, known latency with qualified data. It is the standard delay/alignment element for the lab datapaths.

---
 rtl/reg_pipeline_if.sv | 44 ++++
 rtl/reg_pipeline.sv | 72 +++++++
 2 files changed

// File: rtl/reg_pipeline_if.sv
// +----------------------------------------------------------------------------+
// | reg_pipeline_if                                                            |
// | Producer/consumer bundle for reg_pipeline (occ only with                   |
// | REG_PIPELINE_OCC_EN).                                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface reg_pipeline_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] a;
  logic             a_vld;
  logic             en;
  logic             flush;
  logic [WIDTH-1:0] b;
  logic             b_vld;
  logic [WIDTH-1:0] c;
  logic             c_vld;
`ifdef REG_PIPELINE_OCC_EN
  logic [OCC_W-1:0] occ;
`endif

  modport master (
    output a, a_vld, en, flush,
`ifdef REG_PIPELINE_OCC_EN
    input  occ,
`endif
    input  b, b_vld, c, c_vld
  );

  modport slave (
    input  a, a_vld, en, flush,
`ifdef REG_PIPELINE_OCC_EN
    output occ,
`endif
    output b, b_vld, c, c_vld
  );
endinterface

`default_nettype wire

// File: rtl/reg_pipeline.sv
// +----------------------------------------------------------------------------+
// | reg_pipeline                                                               |
// | WIDTH x DEPTH register delay line with per-stage valid, stall enable and   |
// | synchronous flush. Optional occupancy count: REG_PIPELINE_OCC_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_pipeline #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  reg_pipeline_if.slave bus
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;

  // Data follows en only; flush clears valids but never data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_vld <= '0;
    end else begin
      if (bus.en) begin
        r_data[0] <= bus.a;
        for (int i = 1; i < DEPTH; i++) begin
          r_data[i] <= r_data[i-1];
        end
      end
      if (bus.flush) begin
        r_vld <= '0;
      end else if (bus.en) begin
        r_vld <= {r_vld[DEPTH-2:0], bus.a_vld};
      end
    end
  end

  assign bus.b     = r_data[0];
  assign bus.b_vld = r_vld[0];
  assign bus.c     = r_data[DEPTH-1];
  assign bus.c_vld = r_vld[DEPTH-1];

`ifdef REG_PIPELINE_OCC_EN
  localparam int             OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] C_ONE = OCC_W'(1);

  logic [OCC_W-1:0] r_occ;

  // Word entering and word leaving cancel out, so only the unbalanced cases move the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (bus.flush) begin
      r_occ <= '0;
    end else if (bus.en && bus.a_vld && !r_vld[DEPTH-1]) begin
      r_occ <= r_occ + C_ONE;
    end else if (bus.en && !bus.a_vld && r_vld[DEPTH-1]) begin
      r_occ <= r_occ - C_ONE;
    end
  end

  assign bus.occ = r_occ;
`endif

endmodule

`default_nettype wire
